// File: rtl/ysyx_24110015_ifu_pkg.sv
// Shared core definitions for the instruction fetch unit.
//   ifu_state_e : FSM state encoding (fetch -> wait -> out -> next)
//   INST_NOP    : instruction substituted on a faulted fetch (addi x0,x0,0)
//   RESP_OKAY   : read response code for a successful access
package ysyx_24110015_ifu_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_OUT   = 2'd2,
        S_NEXT  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_24110015_ifu.sv
// Instruction fetch unit: owns the pc, issues one instruction-memory read per
// instruction and hands the result (or a fault) to decode.
//   clk, rst                 : clock; asynchronous active-low reset
//   in_valid/in_ready/dnpc   : next-pc handshake from execute
//   araddr/arvalid/arready   : read-address channel (araddr is always pc)
//   rdata/rresp/rvalid/rready: read-data channel
//   out_valid/out_ready      : inst/pc/fault handshake towards decode
//   fetch_cnt                : number of instructions consumed by decode
module ysyx_24110015_ifu
    import ysyx_24110015_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dnpc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        fault,
    output logic [31:0] fetch_cnt
);

    ifu_state_e state_q;
    ifu_state_e state_d;

    logic ar_fire;
    logic r_fire;
    logic out_fire;
    logic in_fire;
    logic dnpc_misaligned;

    assign araddr          = pc;
    assign ar_fire         = arvalid & arready;
    assign r_fire          = rvalid & rready;
    assign out_fire        = out_valid & out_ready;
    assign in_fire         = in_valid & in_ready;
    assign dnpc_misaligned = (dnpc[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs come from the state register alone; the reset gate
    // keeps them quiet while rst is held low, since the state register
    // already reads S_FETCH during reset.
    always_comb begin
        arvalid   = 1'b0;
        rready    = 1'b0;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        if (rst) begin
            unique case (state_q)
                S_FETCH: arvalid   = 1'b1;
                S_WAIT:  rready    = 1'b1;
                S_OUT:   out_valid = 1'b1;
                S_NEXT:  in_ready  = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: if (ar_fire)  state_d = S_WAIT;
            S_WAIT:  if (r_fire)   state_d = S_OUT;
            S_OUT:   if (out_fire) state_d = S_NEXT;
            S_NEXT:  if (in_fire)  state_d = dnpc_misaligned ? S_OUT : S_FETCH;
        endcase
    end

    // A misaligned dnpc skips memory entirely and is presented as a faulted
    // nop at that pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            inst      <= '0;
            fault     <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            if (r_fire) begin
                if (rresp == RESP_OKAY) begin
                    inst  <= rdata;
                    fault <= 1'b0;
                end else begin
                    inst  <= INST_NOP;
                    fault <= 1'b1;
                end
            end
            if (out_fire) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (in_fire) begin
                pc <= dnpc;
                if (dnpc_misaligned) begin
                    inst  <= INST_NOP;
                    fault <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ysyx_24110015_ifu.md
YSYX_24110015_IFU -- requirements
Module: ysyx_24110015_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning reset, asynchronous and active-low (rst=0 resets).
REQ-004 SHALL have port in_valid  input  1  meaning the next-PC from the execute stage is valid.
REQ-005 SHALL have port in_ready  output  1  meaning the IFU accepts dnpc this cycle.
REQ-006 SHALL have port dnpc  input  32  meaning the next fetch address.
REQ-007 SHALL have port araddr  output  32  meaning the instruction memory read address.
REQ-008 SHALL have port arvalid  output  1  meaning a read request is pending.
REQ-009 SHALL have port arready  input  1  meaning memory accepts the request.
REQ-010 SHALL have port rdata  input  32  meaning the read data.
REQ-011 SHALL have port rresp  input  2  meaning the response code; 2'b00 is OK, anything else is an error.
REQ-012 SHALL have port rvalid  input  1  meaning the read data is valid.
REQ-013 SHALL have port rready  output  1  meaning the IFU accepts read data.
REQ-014 SHALL have port out_valid  output  1  meaning inst/pc/fault are valid for the decode stage.
REQ-015 SHALL have port out_ready  input  1  meaning the decode stage consumes the output.
REQ-016 SHALL have ports inst  output  32, pc  output  32, fault  output  1, and fetch_cnt  output  32 (count of completed fetches).

Function
REQ-017 SHALL implement a four-state FSM:
- S_FETCH: arvalid=1.
- S_WAIT: rready=1.
- S_OUT: out_valid=1.
- S_NEXT: in_ready=1.
Every other handshake output SHALL be 0 in each state.
REQ-018 SHALL drive araddr=pc at all times; pc SHALL be stable from S_FETCH entry until the next dnpc acceptance.
REQ-019 S_FETCH SHALL go to S_WAIT on arvalid&arready; otherwise it holds with arvalid asserted.
REQ-020 S_WAIT SHALL go to S_OUT on rvalid&rready, and SHALL capture the response as follows:
- rresp==0: inst<=rdata, fault<=0.
- rresp!=0: inst<=32'h0000_0013 (nop), fault<=1.
REQ-021 rvalid SHALL be ignored outside S_WAIT, and arready SHALL be ignored outside S_FETCH.
REQ-022 S_OUT SHALL hold out_valid with inst/pc/fault stable until out_valid&out_ready, then go to S_NEXT.
REQ-023 S_NEXT SHALL capture pc<=dnpc on in_valid&in_ready, as follows:
- dnpc[1:0]==0: go to S_FETCH.
- dnpc[1:0]!=0 (misaligned): go directly to S_OUT with inst=32'h0000_0013 and fault=1, issuing no memory request.
REQ-024 fetch_cnt SHALL increment by 1 on each out_valid&out_ready and wrap from 32'hFFFF_FFFF to 0.
REQ-025 Minimum latency SHALL be one cycle per state, i.e. 4 cycles per instruction with zero-wait memory and always-ready neighbours.
REQ-026 No combinational path SHALL exist from any input to any output except araddr=pc; all handshake outputs SHALL be decoded from the state register only.

Reset
REQ-027 On rst=0, asynchronously and irrespective of state, the block SHALL force the following reset values: state=S_FETCH, pc=RESET_PC, inst=0, fault=0, fetch_cnt=0.
REQ-028 While rst=0, all handshake outputs (arvalid, rready, out_valid, in_ready) SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abandon that transaction; a read response arriving after reset release SHALL be ignored because the FSM is in S_FETCH.
REQ-030 After rst rises, the first arvalid SHALL appear in the first cycle, with araddr=RESET_PC.

Structure
REQ-031 The FSM state encoding, the nop constant 32'h0000_0013, and the RESP_OKAY constant SHALL live in a shared core package.
REQ-032 The block SHALL be one module with no sub-modules; the pc register SHALL move from the existing Pc block into this block.

Verification
REQ-033 Release reset with arready=1, rvalid=1 one cycle later, rdata=32'h0010_0093, out_ready=1, in_valid=1, dnpc=32'h8000_0004 -> araddr=32'h8000_0000 then inst=32'h0010_0093, fault=0, and the next araddr=32'h8000_0004 four cycles after the first.
REQ-034 Hold arready=0 for 5 cycles -> arvalid stays 1 with araddr constant, and no out_valid.
REQ-035 Return rvalid with rresp=2'b10 -> inst=32'h0000_0013, fault=1, out_valid=1.
REQ-036 Present dnpc=32'h8000_0006 -> no arvalid, then out_valid with fault=1 and pc=32'h8000_0006.
REQ-037 Hold out_ready=0 for 3 cycles -> out_valid, inst and pc remain stable, fetch_cnt stays unchanged, and in_ready=0.
REQ-038 Assert rst=0 during S_WAIT, then release -> arvalid=1 with araddr=RESET_PC and fetch_cnt=0; a stale rvalid delivered in that first cycle is not captured.
